// File: rtl/uart_rx_midsample.sv
// 8N1 UART receiver: two-flop line synchroniser, mid-bit sampling, false-start
// rejection, framing-error flag and one-cycle strobes for each received byte.
module uart_rx_midsample #(
   parameter int CLOCKS_PER_BIT = 10417,
   parameter int CNT_W          = 14
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       Rx,
   output logic [7:0] Rx_Data,
   output logic       Rx_DataValid,
   output logic       Rx_FrameError,
   output logic       Rx_Busy
);

   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLOCKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLOCKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_CLEANUP   = 3'd4,
      ST_WAIT_HIGH = 3'd5
   } state_t;

   logic             rx_meta_r;
   logic             rx_sync_r;
   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [2:0]       idx_r;
   logic [2:0]       idx_nxt_s;
   logic [7:0]       shift_r;
   logic [7:0]       shift_nxt_s;
   logic [7:0]       data_nxt_s;
   logic             valid_nxt_s;
   logic             ferr_nxt_s;

   // Two-flop synchroniser; resets to the idle (high) line level.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
      end else begin
         rx_meta_r <= Rx;
         rx_sync_r <= rx_meta_r;
      end
   end

   // State, timing and output registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r       <= ST_IDLE;
         cnt_r         <= CNT_ZERO;
         idx_r         <= 3'd0;
         shift_r       <= 8'h00;
         Rx_Data       <= 8'h00;
         Rx_DataValid  <= 1'b0;
         Rx_FrameError <= 1'b0;
         Rx_Busy       <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         cnt_r         <= cnt_nxt_s;
         idx_r         <= idx_nxt_s;
         shift_r       <= shift_nxt_s;
         Rx_Data       <= data_nxt_s;
         Rx_DataValid  <= valid_nxt_s;
         Rx_FrameError <= ferr_nxt_s;
         Rx_Busy       <= (state_r != ST_IDLE);
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      idx_nxt_s   = idx_r;
      shift_nxt_s = shift_r;
      data_nxt_s  = Rx_Data;
      valid_nxt_s = 1'b0;
      ferr_nxt_s  = 1'b0;

      case (state_r)
         ST_IDLE: begin
            cnt_nxt_s = CNT_ZERO;
            idx_nxt_s = 3'd0;
            if (!rx_sync_r) begin
               state_nxt_s = ST_START;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_START: begin
            // A line that is high again at mid start bit was only a glitch.
            if (cnt_r == HALF_CNT) begin
               cnt_nxt_s = CNT_ZERO;
               if (!rx_sync_r) begin
                  state_nxt_s = ST_DATA;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         ST_DATA: begin
            if (cnt_r == LAST_CNT) begin
               cnt_nxt_s          = CNT_ZERO;
               shift_nxt_s[idx_r] = rx_sync_r;
               if (idx_r == 3'd7) begin
                  idx_nxt_s   = 3'd0;
                  state_nxt_s = ST_STOP;
               end else begin
                  idx_nxt_s = idx_r + 3'd1;
               end
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         ST_STOP: begin
            if (cnt_r == LAST_CNT) begin
               cnt_nxt_s = CNT_ZERO;
               if (rx_sync_r) begin
                  data_nxt_s  = shift_r;
                  valid_nxt_s = 1'b1;
                  state_nxt_s = ST_CLEANUP;
               end else begin
                  ferr_nxt_s  = 1'b1;
                  state_nxt_s = ST_WAIT_HIGH;
               end
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         ST_CLEANUP: begin
            state_nxt_s = ST_IDLE;
         end
         ST_WAIT_HIGH: begin
            // A held-low line (break) must not be mistaken for a new start bit.
            if (rx_sync_r) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WAIT_HIGH;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
            idx_nxt_s   = 3'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_rx_midsample.sv
// Directed bench for uart_rx_midsample at 16 clocks per bit: a transmit task
// drives Rx, negedge monitors count strobes, immediate assertions check results.
module tb_uart_rx_midsample;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       Rx;
   logic [7:0] Rx_Data;
   logic       Rx_DataValid;
   logic       Rx_FrameError;
   logic       Rx_Busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int valid_cnt = 0;
   int ferr_cnt = 0;
   int both_cnt = 0;
   int busy_hi_cnt = 0;
   int busy_fall_cnt = 0;
   int valid_cyc = 0;
   int busy_fall_cyc = 0;
   logic busy_prev = 1'b0;
   int fall_cyc = 0;
   int v0, e0, b0, f0;

   uart_rx_midsample #(.CLOCKS_PER_BIT(16), .CNT_W(8)) dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .Rx           (Rx),
      .Rx_Data      (Rx_Data),
      .Rx_DataValid (Rx_DataValid),
      .Rx_FrameError(Rx_FrameError),
      .Rx_Busy      (Rx_Busy)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   // Strobe/busy monitors sampled on the falling edge.
   always @(negedge Clk) begin
      busy_prev <= Rx_Busy;
      if (Rx_DataValid) begin
         valid_cnt <= valid_cnt + 1;
         valid_cyc <= cyc;
      end
      if (Rx_FrameError) ferr_cnt <= ferr_cnt + 1;
      if (Rx_DataValid && Rx_FrameError) both_cnt <= both_cnt + 1;
      if (Rx_Busy) busy_hi_cnt <= busy_hi_cnt + 1;
      if (busy_prev && !Rx_Busy) begin
         busy_fall_cnt <= busy_fall_cnt + 1;
         busy_fall_cyc <= cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge Clk);
      #1;
   endtask

   task automatic snap();
      v0 = valid_cnt;
      e0 = ferr_cnt;
      b0 = busy_hi_cnt;
      f0 = busy_fall_cnt;
   endtask

   task automatic send_frame(input logic [7:0] b, input int n, input logic stop);
      fall_cyc = cyc;
      Rx = 1'b0;
      repeat (n) @(negedge Clk);
      for (int i = 0; i < 8; i++) begin
         Rx = b[i];
         repeat (n) @(negedge Clk);
      end
      Rx = stop;
      repeat (n) @(negedge Clk);
   endtask

   initial begin
      Rx = 1'b1;
      Reset_n = 1'b0;
      idle(3);
      check("reset_data", 32'(Rx_Data), 32'h00);
      check("reset_valid", 32'(Rx_DataValid), 32'd0);
      check("reset_ferr", 32'(Rx_FrameError), 32'd0);
      check("reset_busy", 32'(Rx_Busy), 32'd0);
      Reset_n = 1'b1;
      idle(20);

      // Valid strobe: 2 sync cycles + 1 IDLE detect cycle + 152 from START entry.
      snap();
      send_frame(8'hA5, 16, 1'b1);
      idle(20);
      check("a5_data", 32'(Rx_Data), 32'hA5);
      check("a5_valid_cnt", 32'(valid_cnt - v0), 32'd1);
      check("a5_ferr_cnt", 32'(ferr_cnt - e0), 32'd0);
      check("a5_latency", 32'(valid_cyc - fall_cyc), 32'd155);
      check("a5_busy_fall", 32'(busy_fall_cyc - valid_cyc), 32'd2);

      snap();
      send_frame(8'h00, 16, 1'b1);
      check("b2b_first_data", 32'(Rx_Data), 32'h00);
      send_frame(8'hFF, 16, 1'b1);
      idle(20);
      check("b2b_second_data", 32'(Rx_Data), 32'hFF);
      check("b2b_valid_cnt", 32'(valid_cnt - v0), 32'd2);
      check("b2b_ferr_cnt", 32'(ferr_cnt - e0), 32'd0);

      // 4-cycle glitch: START lasts H+1 = 8 cycles, then back to IDLE.
      snap();
      Rx = 1'b0;
      repeat (4) @(negedge Clk);
      Rx = 1'b1;
      idle(30);
      check("glitch_valid_cnt", 32'(valid_cnt - v0), 32'd0);
      check("glitch_ferr_cnt", 32'(ferr_cnt - e0), 32'd0);
      check("glitch_data", 32'(Rx_Data), 32'hFF);
      check("glitch_busy_cycles", 32'(busy_hi_cnt - b0), 32'd8);

      send_frame(8'hA5, 16, 1'b1);
      idle(20);
      check("pre_ferr_data", 32'(Rx_Data), 32'hA5);
      snap();
      send_frame(8'h3C, 16, 1'b0);
      #1;
      check("ferr_cnt", 32'(ferr_cnt - e0), 32'd1);
      check("ferr_valid_cnt", 32'(valid_cnt - v0), 32'd0);
      check("ferr_data_held", 32'(Rx_Data), 32'hA5);
      f0 = busy_fall_cnt;
      idle(40);
      check("break_busy", 32'(Rx_Busy), 32'd1);
      check("break_no_restart", 32'(busy_fall_cnt - f0), 32'd0);
      check("break_ferr_once", 32'(ferr_cnt - e0), 32'd1);
      Rx = 1'b1;
      idle(20);
      check("break_release_busy", 32'(Rx_Busy), 32'd0);
      snap();
      send_frame(8'h81, 16, 1'b1);
      idle(20);
      check("post_break_data", 32'(Rx_Data), 32'h81);
      check("post_break_valid", 32'(valid_cnt - v0), 32'd1);
      check("post_break_ferr", 32'(ferr_cnt - e0), 32'd0);

      // Abort a frame of 0x0F halfway through data bit 4.
      Rx = 1'b0;
      repeat (16) @(negedge Clk);
      for (int i = 0; i < 4; i++) begin
         Rx = 1'b1;
         repeat (16) @(negedge Clk);
      end
      Rx = 1'b0;
      repeat (8) @(negedge Clk);
      #1;
      check("midframe_busy", 32'(Rx_Busy), 32'd1);
      Reset_n = 1'b0;
      #1;
      check("midreset_data", 32'(Rx_Data), 32'h00);
      check("midreset_valid", 32'(Rx_DataValid), 32'd0);
      check("midreset_ferr", 32'(Rx_FrameError), 32'd0);
      check("midreset_busy", 32'(Rx_Busy), 32'd0);
      Rx = 1'b1;
      repeat (4) @(negedge Clk);
      Reset_n = 1'b1;
      idle(30);
      snap();
      send_frame(8'h5A, 16, 1'b1);
      idle(20);
      check("after_reset_data", 32'(Rx_Data), 32'h5A);
      check("after_reset_valid", 32'(valid_cnt - v0), 32'd1);
      check("after_reset_ferr", 32'(ferr_cnt - e0), 32'd0);

      // Bit-period margin. At 17 clocks/bit the stop sample lands in data bit 7;
      // at 15 clocks/bit samples 6 and 7 land in bit 7 and the stop bit, so both
      // bytes keep bits 7 and 6 set to come through intact.
      snap();
      send_frame(8'hC3, 17, 1'b1);
      idle(30);
      check("slow_data", 32'(Rx_Data), 32'hC3);
      send_frame(8'hDB, 15, 1'b1);
      idle(30);
      check("fast_data", 32'(Rx_Data), 32'hDB);
      check("margin_valid_cnt", 32'(valid_cnt - v0), 32'd2);
      check("margin_ferr_cnt", 32'(ferr_cnt - e0), 32'd0);

      check("never_both_strobes", 32'(both_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
